sent_frame_buf: RTL and testbench

- Per-channel frame buffer between the SENT parameter/frame parser and the per-channel SENT frame generator.
- Captures frame words broadcast by the parser that are addressed to this channel, and queues them in a small FIFO.
- Hands frames to the generator over a valid/ready handshake, so UDP bursts are not lost while a frame is being transmitted.
- One instance per channel, instantiated inside the same generate loop as the generator.

---
 rtl/sent_frame_buf.sv | 143 ++++++++++++++
 tb/tb_sent_frame_buf.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sent_frame_buf.sv
// Per-channel SENT frame buffer: captures parser frame words addressed to
// this channel and queues them in a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   sent_config_vld      config strobe; flushes the FIFO when channel matches
//   sent_config_channel  channel index for both config and frame strobes
//   sent_frame_vld/data  frame strobe and word from the parser
//   frame_vld/data/rdy   valid/ready handshake towards the frame generator
//   fifo_level           occupancy 0..2**FIFO_AW
//   drop_cnt             saturating count of frames dropped while full
//   overflow             one-cycle pulse per dropped frame
//
// Optional: define SENT_FRAME_REPEAT_EN to keep re-presenting the last
// popped frame while the FIFO is empty.

module sent_frame_buf #(
    parameter int unsigned CHANNEL_INDEX = 0,
    parameter int unsigned FIFO_AW       = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sent_config_vld,
    input  logic [7:0]         sent_config_channel,
    input  logic               sent_frame_vld,
    input  logic [31:0]        sent_frame_data,
    output logic               frame_vld,
    output logic [31:0]        frame_data,
    input  logic               frame_rdy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [15:0]        drop_cnt,
    output logic               overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [7:0]  CH    = 8'(CHANNEL_INDEX);

    logic [31:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic [15:0]        drop_q, drop_d;
    logic               ovf_q, ovf_d;

    logic hit, flush, push_req, empty, full, pop, push_ok, drop;

    assign hit      = (sent_config_channel == CH);
    assign flush    = sent_config_vld & hit;
    assign push_req = sent_frame_vld & hit;
    assign empty    = (level_q == '0);
    // Level never exceeds DEPTH, so its MSB alone marks full.
    assign full     = level_q[FIFO_AW];
    assign pop      = frame_rdy & ~empty & ~flush;
    assign push_ok  = push_req & ~flush & (~full | pop);
    assign drop     = push_req & ~flush & full & ~pop;

`ifdef SENT_FRAME_REPEAT_EN
    logic [31:0] last_q, last_d;
    logic        has_last_q, has_last_d;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        drop_d   = drop_q;
        ovf_d    = 1'b0;
`ifdef SENT_FRAME_REPEAT_EN
        last_d     = last_q;
        has_last_d = has_last_q;
`endif
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
`ifdef SENT_FRAME_REPEAT_EN
            last_d     = '0;
            has_last_d = 1'b0;
`endif
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
`ifdef SENT_FRAME_REPEAT_EN
                last_d     = mem_q[rd_ptr_q];
                has_last_d = 1'b1;
`endif
            end
            case ({push_ok, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != 16'hFFFF) drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
`ifdef SENT_FRAME_REPEAT_EN
            last_q     <= '0;
            has_last_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
`ifdef SENT_FRAME_REPEAT_EN
            last_q     <= last_d;
            has_last_q <= has_last_d;
`endif
        end
    end

    // Storage needs no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= sent_frame_data;
    end

`ifdef SENT_FRAME_REPEAT_EN
    assign frame_vld  = ~empty | has_last_q;
    assign frame_data = ~empty    ? mem_q[rd_ptr_q] :
                        has_last_q ? last_q : 32'h0;
`else
    assign frame_vld  = ~empty;
    assign frame_data = empty ? 32'h0 : mem_q[rd_ptr_q];
`endif

    assign fifo_level = level_q;
    assign drop_cnt   = drop_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_sent_frame_buf.sv
// Self-checking bench for sent_frame_buf: directed table, corner
// sequences and randomized traffic against a queue-based model.

module tb_sent_frame_buf;

    localparam int unsigned CHI   = 3;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 1 << AW;
`ifdef SENT_FRAME_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_vld;
    logic [7:0]  cfg_ch;
    logic        fr_vld;
    logic [31:0] fr_data;
    logic        frame_vld;
    logic [31:0] frame_data;
    logic        frame_rdy;
    logic [AW:0] fifo_level;
    logic [15:0] drop_cnt;
    logic        overflow;

    sent_frame_buf #(.CHANNEL_INDEX(CHI), .FIFO_AW(AW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .sent_config_vld     (cfg_vld),
        .sent_config_channel (cfg_ch),
        .sent_frame_vld      (fr_vld),
        .sent_frame_data     (fr_data),
        .frame_vld           (frame_vld),
        .frame_data          (frame_data),
        .frame_rdy           (frame_rdy),
        .fifo_level          (fifo_level),
        .drop_cnt            (drop_cnt),
        .overflow            (overflow)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: ordered queue of words plus drop/repeat state.
    logic [31:0]  mq[$];
    int unsigned  m_drop;
    bit           m_ovf;
    bit           m_has;
    logic [31:0]  m_last;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else
            passed++;
    endtask

    function automatic logic exp_vld();
        return (mq.size() != 0) || (REP && m_has);
    endfunction

    function automatic logic [31:0] exp_data();
        if (mq.size() != 0) return mq[0];
        if (REP && m_has) return m_last;
        return 32'h0;
    endfunction

    task automatic model_step(bit r, bit c, logic [7:0] ch, bit f,
                              logic [31:0] d, bit rdy);
        bit hit;
        bit popped;
        int pre;
        hit = (ch == 8'(CHI));
        m_ovf = 1'b0;
        if (r) begin
            mq.delete();
            m_drop = 0;
            m_has = 1'b0;
            m_last = '0;
        end else if (c && hit) begin
            mq.delete();
            m_has = 1'b0;
            m_last = '0;
        end else begin
            pre = mq.size();
            popped = rdy && (pre > 0);
            if (popped) begin
                m_last = mq.pop_front();
                m_has = REP;
            end
            if (f && hit) begin
                if (pre < DEPTH || popped) mq.push_back(d);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 16'hFFFF) m_drop++;
                end
            end
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, ".level"}, 32'(fifo_level), 32'(mq.size()));
        chk({tag, ".vld"},   32'(frame_vld),  32'(exp_vld()));
        chk({tag, ".data"},  frame_data,      exp_data());
        chk({tag, ".drop"},  32'(drop_cnt),   m_drop);
        chk({tag, ".ovf"},   32'(overflow),   32'(m_ovf));
    endtask

    task automatic cycle(bit r, bit c, logic [7:0] ch, bit f,
                         logic [31:0] d, bit rdy, string tag);
        rst = r; cfg_vld = c; cfg_ch = ch;
        fr_vld = f; fr_data = d; frame_rdy = rdy;
        @(posedge clk);
        model_step(r, c, ch, f, d, rdy);
        #1;
        check_model(tag);
    endtask

    task automatic push(logic [31:0] d, bit rdy, string tag);
        cycle(1'b0, 1'b0, 8'(CHI), 1'b1, d, rdy, tag);
    endtask

    task automatic idle(bit rdy, string tag);
        cycle(1'b0, 1'b0, 8'(CHI), 1'b0, 32'h0, rdy, tag);
    endtask

    task automatic do_reset(string tag);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, tag);
    endtask

    typedef struct {
        bit          cfg;
        logic [7:0]  ch;
        bit          fv;
        logic [31:0] fd;
        bit          rdy;
        int          e_level;
        bit          e_vld;
        logic [31:0] e_data;
        int          e_drop;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] rep_d;
        rep_d = REP ? 32'h33333333 : 32'h0;
        vecs[0] = '{1'b0, 8'(CHI),   1'b1, 32'h11111111, 1'b0, 1, 1'b1, 32'h11111111, 0};
        vecs[1] = '{1'b0, 8'(CHI),   1'b1, 32'h22222222, 1'b0, 2, 1'b1, 32'h11111111, 0};
        vecs[2] = '{1'b0, 8'(CHI),   1'b1, 32'h33333333, 1'b0, 3, 1'b1, 32'h11111111, 0};
        vecs[3] = '{1'b0, 8'(CHI),   1'b0, 32'h0,        1'b1, 2, 1'b1, 32'h22222222, 0};
        vecs[4] = '{1'b0, 8'(CHI),   1'b0, 32'h0,        1'b1, 1, 1'b1, 32'h33333333, 0};
        vecs[5] = '{1'b0, 8'(CHI),   1'b0, 32'h0,        1'b1, 0, REP,  rep_d,        0};
        vecs[6] = '{1'b0, 8'(CHI+1), 1'b1, 32'hDEADBEEF, 1'b0, 0, REP,  rep_d,        0};
        vecs[7] = '{1'b1, 8'(CHI+1), 1'b1, 32'hCAFEF00D, 1'b1, 0, REP,  rep_d,        0};

        rst = 1'b1; cfg_vld = 1'b0; cfg_ch = '0;
        fr_vld = 1'b0; fr_data = '0; frame_rdy = 1'b0;
        m_drop = 0; m_ovf = 1'b0; m_has = 1'b0; m_last = '0;

        do_reset("rst0");
        chk("rst0.vld_const",   32'(frame_vld),  32'h0);
        chk("rst0.level_const", 32'(fifo_level), 32'h0);
        chk("rst0.data_const",  frame_data,      32'h0);

        // Directed table: fill, drain in order, foreign channel.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, vecs[i].cfg, vecs[i].ch, vecs[i].fv,
                  vecs[i].fd, vecs[i].rdy, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.e_level", i), 32'(fifo_level), 32'(vecs[i].e_level));
            chk($sformatf("tbl%0d.e_vld", i),   32'(frame_vld),  32'(vecs[i].e_vld));
            chk($sformatf("tbl%0d.e_data", i),  frame_data,      vecs[i].e_data);
            chk($sformatf("tbl%0d.e_drop", i),  32'(drop_cnt),   32'(vecs[i].e_drop));
        end

        // Overflow: 9 pushes into a depth-8 FIFO.
        do_reset("rst1");
        for (int i = 0; i < 9; i++) push(32'h100 + 32'(i), 1'b0, $sformatf("ovf%0d", i));
        chk("ovf.level8", 32'(fifo_level), 32'd8);
        chk("ovf.pulse",  32'(overflow),   32'd1);
        chk("ovf.drop1",  32'(drop_cnt),   32'd1);
        chk("ovf.head",   frame_data,      32'h100);
        idle(1'b0, "ovf_idle");
        chk("ovf.pulse_once", 32'(overflow), 32'd0);
        // Full with simultaneous push and pop.
        push(32'h200, 1'b1, "fullpp");
        chk("fullpp.level", 32'(fifo_level), 32'd8);
        chk("fullpp.noovf", 32'(overflow),   32'd0);
        chk("fullpp.head",  frame_data,      32'h101);

        // Flush while full, then queue 4 and flush together with a push.
        cycle(1'b0, 1'b1, 8'(CHI), 1'b0, 32'h0, 1'b0, "flush_full");
        for (int i = 0; i < 4; i++) push(32'h300 + 32'(i), 1'b0, "fl_q");
        cycle(1'b0, 1'b1, 8'(CHI), 1'b1, 32'h399, 1'b1, "flush_push");
        chk("flush.level", 32'(fifo_level), 32'd0);
        chk("flush.vld",   32'(frame_vld),  32'd0);
        chk("flush.drop",  32'(drop_cnt),   32'd1);
        chk("flush.noovf", 32'(overflow),   32'd0);
        idle(1'b1, "empty_rdy");
        chk("empty_rdy.level", 32'(fifo_level), 32'd0);

`ifdef SENT_FRAME_REPEAT_EN
        push(32'hA5A5A5A5, 1'b0, "rep_push");
        idle(1'b1, "rep_pop");
        for (int i = 0; i < 10; i++) begin
            idle(1'b1, "rep_hs");
            chk("rep.vld",  32'(frame_vld), 32'd1);
            chk("rep.data", frame_data,     32'hA5A5A5A5);
        end
        push(32'h5A5A5A5A, 1'b0, "rep_new");
        chk("rep_new.data", frame_data, 32'h5A5A5A5A);
        cycle(1'b0, 1'b1, 8'(CHI), 1'b0, 32'h0, 1'b0, "rep_flush");
        chk("rep_flush.vld", 32'(frame_vld), 32'd0);
`endif

        // Reset with 5 frames queued.
        for (int i = 0; i < 5; i++) push(32'h400 + 32'(i), 1'b0, "rq");
        chk("rq.level5", 32'(fifo_level), 32'd5);
        do_reset("rst_mid");
        chk("rst_mid.level", 32'(fifo_level), 32'd0);
        chk("rst_mid.vld",   32'(frame_vld),  32'd0);
        chk("rst_mid.drop",  32'(drop_cnt),   32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, c, f, rd;
            logic [7:0] ch;
            r  = ($urandom_range(0, 399) == 0);
            c  = ($urandom_range(0, 39) == 0);
            f  = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 40);
            ch = ($urandom_range(0, 3) == 0) ? 8'(CHI + 1) : 8'(CHI);
            cycle(r, c, ch, f, $urandom, rd, "rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
